instr_encoder: RTL and testbench

- Inverse of the immediate decode path: accepts decoded ADDI/BNE fields and packs them into 32-bit RV32I instruction words.
- Range-checks each immediate before packing.
- Writes each legal word sequentially into instruction memory through a single write port.
- Used as the program loader feeding instruction memory ahead of CPU execution.

---
 rtl/instr_encoder_pkg.sv | 46 ++++
 rtl/instr_pack.sv | 38 +++
 rtl/instr_encoder.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// Module  : instr_encoder_pkg
// Brief   : Shared types and constants for the RV32I ADDI/BNE program loader.
//           INSTR_ENCODER_NOP_PAD_EN adds the PAD state to the FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

  // Operation selector carried on in_op; encodings 2 and 3 are illegal.
  typedef enum logic [1:0] {
    OP_ADDI = 2'd0,
    OP_BNE  = 2'd1
  } op_e;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_ADDI    = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;
  localparam logic [31:0] NOP_WORD   = 32'h00000013;

  // Representable immediate ranges (I-type 12-bit, B-type 13-bit even).
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;

`ifdef INSTR_ENCODER_NOP_PAD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_PAD   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module  : instr_pack
// Brief   : Combinational packer: decoded fields + op -> 32-bit word and a
//           legality flag covering the op code and the immediate range.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  // Select the instruction format and check that the immediate fits it.
  always_comb begin
    word_o  = 32'h0;
    legal_o = 1'b0;
    if (op_i == OP_ADDI) begin
      word_o  = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OPC_OP_IMM};
      legal_o = ($signed(imm_i) >= IMM_I_MIN) && ($signed(imm_i) <= IMM_I_MAX);
    end else if (op_i == OP_BNE) begin
      word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BNE,
                 imm_i[4:1], imm_i[11], OPC_BRANCH};
      legal_o = ($signed(imm_i) >= IMM_B_MIN) && ($signed(imm_i) <= IMM_B_MAX)
                && !imm_i[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Brief   : Program loader. Accepts ADDI/BNE field bundles, packs them via
//           instr_pack and writes legal words sequentially into instruction
//           memory. Define INSTR_ENCODER_NOP_PAD_EN to pad the remaining
//           memory with NOPs on flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [1:0]        op_q;
  logic [4:0]        rd_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [31:0]       imm_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic              done_q;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W:0]   count_inc;

  instr_pack u_pack (
    .op_i    (op_q),
    .rd_i    (rd_q),
    .rs1_i   (rs1_q),
    .rs2_i   (rs2_q),
    .imm_i   (imm_q),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  assign count_inc = count_q + 1'b1;
  assign full      = (count_q == DEPTH_CNT);
  // flush wins over in_valid, and clear blocks acceptance in the same cycle.
  assign in_ready  = !rst && (state_q == ST_IDLE) && !full && !clear && !flush;
  // A clear arriving during a write cycle suppresses the strobe immediately.
  assign mem_we    = mem_we_q && !clear;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign done      = done_q;

  // Loader FSM: accept -> ENC (pack/check) -> WRITE (strobe, bump count).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'd0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      imm_q       <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      mem_we_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
            if (full) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= ST_PAD;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= count_q[ADDR_W-1:0];
              mem_wdata_q <= NOP_WORD;
            end
`else
            done_q <= 1'b1;
`endif
          end else if (in_valid && !full) begin
            op_q    <= in_op;
            rd_q    <= in_rd;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            imm_q   <= in_imm;
            state_q <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (enc_legal) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= count_q[ADDR_W-1:0];
            mem_wdata_q <= enc_word;
            state_q     <= ST_WRITE;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          count_q <= count_inc;
          state_q <= ST_IDLE;
        end
`ifdef INSTR_ENCODER_NOP_PAD_EN
        ST_PAD: begin
          count_q <= count_inc;
          if (count_inc == DEPTH_CNT) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= count_inc[ADDR_W-1:0];
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module  : tb_instr_encoder
// Brief   : Self-checking bench for instr_encoder (DEPTH=4), with a
//           behavioural encoder model and write/done monitors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, clear, flush, in_valid, in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full, err, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_count  = 0;
  int m_err    = 0;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  int bnd[10] = '{-2049, -2048, 2047, 2048, -4098, -4097, -4096, 4094, 4095, 4096};

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced at each active edge.
  always @(posedge clk) cyc = cyc + 1;

  // Record memory writes and done pulses mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      w.cyc  = cyc;
      w.addr = int'(mem_addr);
      w.data = mem_wdata;
      wq.push_back(w);
    end
    if (done === 1'b1) dq.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: instruction fields assembled from shifted/masked arithmetic.
  function automatic void model_enc(input int op, input int rd, input int rs1,
                                    input int rs2, input int imm,
                                    output bit legal, output logic [31:0] word);
    logic [31:0] u;
    u     = imm;
    legal = 1'b0;
    word  = 32'h0;
    if (op == 0) begin
      legal = (imm >= -2048) && (imm <= 2047);
      word  = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
    end else if (op == 1) begin
      legal = (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
      word  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
              (32'(rs2) << 20) | (32'(rs1) << 15) | (32'h1 << 12) |
              (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
    end
  endfunction

  // Drive one bundle from a negedge; acc = acceptance cycle or -1 on timeout.
  task automatic send_bundle(input int op, input int rd, input int rs1,
                             input int rs2, input int imm, output int acc);
    int n;
    n        = 0;
    acc      = -1;
    in_op    = op[1:0];
    in_rd    = rd[4:0];
    in_rs1   = rs1[4:0];
    in_rs2   = rs2[4:0];
    in_imm   = imm;
    in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready === 1'b1) acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One-cycle clear pulse; resets the bench model and monitors.
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wq.delete();
    dq.delete();
    m_count = 0;
    m_err   = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d wd=%h cnt=%0d full=%b err=%b done=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, count, full, err, done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || count !== '0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d, required rdy=1 cnt=0", in_ready, count);
    end
  endtask

  task automatic test_known_vectors();
    int          op_t[3]  = '{0, 0, 1};
    int          rd_t[3]  = '{1, 1, 0};
    int          rs1_t[3] = '{0, 1, 1};
    int          rs2_t[3] = '{0, 0, 0};
    int          imm_t[3] = '{5, -1, -4};
    logic [31:0] exp_t[3] = '{32'h00500093, 32'hFFF08093, 32'hFE009EE3};
    int acc;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      wq.delete();
      send_bundle(op_t[i], rd_t[i], rs1_t[i], rs2_t[i], imm_t[i], acc);
      checks++;
      if (wq.size() != 1 || acc < 0) begin
        failures++;
        $display("FAIL known_write_count[%0d]: got %0d writes acc=%0d, required 1", i, wq.size(), acc);
      end else begin
        checks++;
        if (wq[0].cyc != acc + 2 || wq[0].addr != i || wq[0].data !== exp_t[i]) begin
          failures++;
          $display("FAIL known_write[%0d]: got lat=%0d addr=%0d data=%h, required lat=2 addr=%0d data=%h",
                   i, wq[0].cyc - acc, wq[0].addr, wq[0].data, i, exp_t[i]);
        end
      end
      checks++;
      if (count !== (AW+1)'(i + 1)) begin
        failures++;
        $display("FAIL known_count[%0d]: got %0d, required %0d", i, count, i + 1);
      end
    end
  endtask

  task automatic test_illegal();
    int op_t[7]  = '{0, 1, 1, 2, 3, 0, 1};
    int imm_t[7] = '{2048, 3, 4096, 0, 0, -2049, -4098};
    int acc;
    bit          legal;
    logic [31:0] word;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      send_bundle(op_t[i], 3, 4, 5, imm_t[i], acc);
      checks++;
      if (wq.size() != 0 || err !== 1'b1 || count !== '0 || acc < 0) begin
        failures++;
        $display("FAIL illegal[%0d]: got writes=%0d err=%b cnt=%0d acc=%0d, required 0/1/0",
                 i, wq.size(), err, count, acc);
      end
    end
    model_enc(0, 2, 3, 0, 7, legal, word);
    send_bundle(0, 2, 3, 0, 7, acc);
    checks++;
    if (wq.size() != 1 || count !== 3'd1 || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_then_legal: got writes=%0d cnt=%0d err=%b, required 1/1/1",
               wq.size(), count, err);
    end else begin
      checks++;
      if (wq[0].addr != 0 || wq[0].data !== word) begin
        failures++;
        $display("FAIL illegal_then_legal_data: got addr=%0d data=%h, required 0 %h",
                 wq[0].addr, wq[0].data, word);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    do_clear();
    for (int i = 0; i < 3; i++) send_bundle(0, i + 1, i, 0, i * 10, acc[i]);
    checks++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d %0d, required 3 3", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (wq.size() != 3) begin
      failures++;
      $display("FAIL b2b_writes: got %0d, required 3", wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq[i].cyc != acc[i] + 2 || wq[i].addr != i) begin
          failures++;
          $display("FAIL b2b_write[%0d]: got lat=%0d addr=%0d, required 2 %0d",
                   i, wq[i].cyc - acc[i], wq[i].addr, i);
        end
      end
    end
  endtask

  task automatic test_random();
    int op, rd, rs1, rs2, imm, acc, sel;
    bit          legal;
    logic [31:0] word;
    for (int r = 0; r < 6; r++) begin
      do_clear();
      for (int k = 0; k < 7; k++) begin
        if (m_count == DEPTH) break;
        sel = $urandom_range(0, 9);
        op  = (sel < 4) ? 0 : (sel < 8) ? 1 : int'($urandom_range(2, 3));
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        case ($urandom_range(0, 4))
          0:       imm = int'($urandom);
          1:       imm = $urandom_range(0, 4095) - 2048;
          2:       imm = ($urandom_range(0, 4095) - 2048) * 2;
          3:       imm = bnd[$urandom_range(0, 9)];
          default: imm = $urandom_range(0, 16383) - 8192;
        endcase
        model_enc(op, rd, rs1, rs2, imm, legal, word);
        wq.delete();
        send_bundle(op, rd, rs1, rs2, imm, acc);
        if (legal) begin
          checks++;
          if (wq.size() != 1 || acc < 0) begin
            failures++;
            $display("FAIL rand_write op=%0d imm=%0d: got %0d writes, required 1", op, imm, wq.size());
          end else if (wq[0].cyc != acc + 2 || wq[0].addr != m_count || wq[0].data !== word) begin
            failures++;
            $display("FAIL rand_data op=%0d imm=%0d: got lat=%0d addr=%0d data=%h, required 2 %0d %h",
                     op, imm, wq[0].cyc - acc, wq[0].addr, wq[0].data, m_count, word);
          end
          m_count++;
        end else begin
          checks++;
          if (wq.size() != 0) begin
            failures++;
            $display("FAIL rand_nowrite op=%0d imm=%0d: got %0d writes, required 0", op, imm, wq.size());
          end
          m_err = 1;
        end
        checks++;
        if (count !== (AW+1)'(m_count) || err !== m_err[0] || full !== (m_count == DEPTH)) begin
          failures++;
          $display("FAIL rand_state: got cnt=%0d err=%b full=%b, required %0d %0d %0d",
                   count, err, full, m_count, m_err, m_count == DEPTH);
        end
      end
    end
  endtask

  task automatic test_full();
    int acc;
    bit seen_ready;
    do_clear();
    send_bundle(0, 1, 1, 0, 5000, acc);
    for (int i = 0; i < DEPTH; i++) send_bundle(1, 0, i, i + 1, i * 8, acc);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4 || wq.size() != DEPTH) begin
      failures++;
      $display("FAIL full_state: got full=%b rdy=%b cnt=%0d writes=%0d, required 1 0 4 4",
               full, in_ready, count, wq.size());
    end
    wq.delete();
    seen_ready = 1'b0;
    in_op = 2'd0; in_imm = 32'd1; in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (in_ready === 1'b1) seen_ready = 1'b1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seen_ready || wq.size() != 0 || count !== 3'd4) begin
      failures++;
      $display("FAIL full_holdoff: got ready_seen=%b writes=%0d cnt=%0d, required 0 0 4",
               seen_ready, wq.size(), count);
    end
    do_clear();
    #1;
    checks++;
    if (count !== '0 || full !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_clear: got cnt=%0d full=%b err=%b rdy=%b, required 0 0 0 1",
               count, full, err, in_ready);
    end
  endtask

  task automatic test_clear_abort();
    int acc;
    do_clear();
    send_bundle(2, 0, 0, 0, 0, acc);
    // clear during ENC
    in_op = 2'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd5; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_enc_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || count !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL clr_enc: got we=%b cnt=%0d err=%b, required 0 0 0", mem_we, count, err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL clr_enc_nowrite: got %0d writes, required 0", wq.size());
    end
    // clear during WRITE
    in_valid = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 clear = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL clr_write_we: got %b, required 0", mem_we);
    end
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (count !== '0 || wq.size() != 0) begin
      failures++;
      $display("FAIL clr_write: got cnt=%0d writes=%0d, required 0 0", count, wq.size());
    end
  endtask

  task automatic test_rst_mid();
    do_clear();
    in_op = 2'd1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd8; in_valid = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_write: got we=%b, required 1", mem_we);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err, done} !== '0) begin
      failures++;
      $display("FAIL rst_async: got rdy=%b we=%b addr=%0d wd=%h cnt=%0d full=%b err=%b done=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, count, full, err, done);
    end
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (count !== '0 || wq.size() != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_after: got cnt=%0d writes=%0d rdy=%b, required 0 0 1",
               count, wq.size(), in_ready);
    end
  endtask

  task automatic test_flush();
    int acc, f, npad;
    do_clear();
    send_bundle(0, 1, 0, 0, 1, acc);
    send_bundle(0, 2, 0, 0, 2, acc);
    m_count = 2;
    for (int pass = 0; pass < 2; pass++) begin
      wq.delete();
      dq.delete();
      in_op = 2'd0; in_rd = 5'd3; in_imm = 32'd3;
      in_valid = 1'b1;
      flush    = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL flush_ready[%0d]: got %b, required 0", pass, in_ready);
      end
      f = cyc;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
`ifdef INSTR_ENCODER_NOP_PAD_EN
      npad = DEPTH - m_count;
`else
      npad = 0;
`endif
      checks++;
      if (wq.size() != npad) begin
        failures++;
        $display("FAIL flush_writes[%0d]: got %0d, required %0d", pass, wq.size(), npad);
      end else begin
        for (int i = 0; i < npad; i++) begin
          checks++;
          if (wq[i].cyc != f + 1 + i || wq[i].addr != m_count + i || wq[i].data !== 32'h00000013) begin
            failures++;
            $display("FAIL flush_pad[%0d]: got cyc=%0d addr=%0d data=%h, required %0d %0d 00000013",
                     i, wq[i].cyc - f, wq[i].addr, wq[i].data, 1 + i, m_count + i);
          end
        end
      end
      m_count = m_count + npad;
      checks++;
      if (dq.size() != 1 || (dq.size() == 1 && dq[0] != f + npad + 1)) begin
        failures++;
        $display("FAIL flush_done[%0d]: got pulses=%0d first_off=%0d, required 1 at %0d",
                 pass, dq.size(), (dq.size() > 0) ? dq[0] - f : -1, npad + 1);
      end
      checks++;
      if (count !== (AW+1)'(m_count) || full !== (m_count == DEPTH)) begin
        failures++;
        $display("FAIL flush_count[%0d]: got cnt=%0d full=%b, required %0d %0d",
                 pass, count, full, m_count, m_count == DEPTH);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    test_reset();
    test_known_vectors();
    test_illegal();
    test_back_to_back();
    test_random();
    test_full();
    test_clear_abort();
    test_rst_mid();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
